// File: rtl/vga_timing_pkg.sv
// VGA timing constants for 640x480@60 from a 100 MHz system clock.
// Latency: n/a (constants only).
// Backpressure: n/a.
package vga_timing_pkg;

    localparam int VGA_CLK_DIV = 4;

    localparam int VGA_H_VIS   = 640;
    localparam int VGA_H_FP    = 16;
    localparam int VGA_H_SYNC  = 96;
    localparam int VGA_H_BP    = 48;
    localparam int VGA_H_TOTAL = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_VIS   = 480;
    localparam int VGA_V_FP    = 10;
    localparam int VGA_V_SYNC  = 2;
    localparam int VGA_V_BP    = 33;
    localparam int VGA_V_TOTAL = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Sync windows are half-open: [START, END)
    localparam int VGA_H_SYNC_START = VGA_H_VIS + VGA_H_FP;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
    localparam int VGA_V_SYNC_START = VGA_V_VIS + VGA_V_FP;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

    // Width of the pix_x / pix_y coordinate buses
    localparam int COORD_W = 10;

endpackage

// File: rtl/vga_sync_ctrl_if.sv
// Scan-timing bundle between the sync controller and the pixel drawing logic.
// Latency: n/a (wiring only).
// Backpressure: none; en is the only upstream control.
interface vga_sync_ctrl_if;
    import vga_timing_pkg::*;

    logic               en;
    logic               pix_tick;
    logic               hsync;
    logic               vsync;
    logic               video_on;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic               frame_start;

    // Controller side: produces the scan timing
    modport master (
        input  en,
        output pix_tick, hsync, vsync, video_on, pix_x, pix_y, frame_start
    );

    // Consumer side: enables the scan and follows its timing
    modport slave (
        output en,
        input  pix_tick, hsync, vsync, video_on, pix_x, pix_y, frame_start
    );

endinterface

// File: rtl/pix_tick_gen.sv
// Pixel-rate clock enable: divides clk by CLK_DIV without creating a derived clock.
// Latency: tick is combinational from the divider, high in the last clk of each pixel.
// Backpressure: none; en low clears the divider and suppresses tick.
module pix_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    // Count clks within a pixel while enabled; restart on the last one or when idle
    always_comb begin
        div_d = div_q;
        if (!en || (div_q == DIV_LAST)) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Divider state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Gating on rst keeps tick quiet in reset even when CLK_DIV=1 (div is always last)
    assign tick = en && !rst && (div_q == DIV_LAST);

endmodule

// File: rtl/vga_sync_ctrl.sv
// VGA scan sequencer: pixel-rate enable, h/v scan counters, registered sync/video/coordinate decode.
// Latency: decoded outputs follow the scan counters by exactly 1 clk; pix_tick is combinational.
// Backpressure: none; en low clears the scan and forces idle outputs on the next clk.
module vga_sync_ctrl
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = VGA_CLK_DIV,
    parameter int H_VIS    = VGA_H_VIS,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_VIS    = VGA_V_VIS,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    vga_sync_ctrl_if.master vga
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_VIS_C  = HW'(H_VIS);
    localparam logic [HW-1:0] H_SS_C   = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] H_SE_C   = HW'(H_VIS + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_C  = VW'(V_VIS);
    localparam logic [VW-1:0] V_SS_C   = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] V_SE_C   = VW'(V_VIS + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);

    logic               tick;
    logic [HW-1:0]      h_cnt_q, h_cnt_d;
    logic [VW-1:0]      v_cnt_q, v_cnt_d;
    logic               first_q, first_d;
    logic               video_on_q, video_on_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic [COORD_W-1:0] pix_x_q, pix_x_d;
    logic [COORD_W-1:0] pix_y_q, pix_y_d;
    logic               frame_start_q, frame_start_d;
    logic               vis, hs_act, vs_act;

    pix_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (vga.en),
        .tick (tick)
    );

    // Scan counters advance one pixel per tick; en low parks them at (0,0).
    // first_d marks that the next clk is the first clk of a pixel (after a tick or while idle),
    // so frame_start fires once per (0,0) pixel regardless of CLK_DIV.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        first_d = !vga.en || tick;
        if (!vga.en) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (tick) begin
            if (h_cnt_q == H_LAST_C) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST_C) ? '0 : v_cnt_q + VW'(1);
            end else begin
                h_cnt_d = h_cnt_q + HW'(1);
            end
        end
    end

    // Decode the current scan position into next-clk output values
    always_comb begin
        vis           = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
        hs_act        = (h_cnt_q >= H_SS_C) && (h_cnt_q < H_SE_C);
        vs_act        = (v_cnt_q >= V_SS_C) && (v_cnt_q < V_SE_C);
        video_on_d    = 1'b0;
        hsync_d       = ~SYNC_POL;
        vsync_d       = ~SYNC_POL;
        pix_x_d       = '0;
        pix_y_d       = '0;
        frame_start_d = 1'b0;
        if (vga.en) begin
            video_on_d    = vis;
            hsync_d       = hs_act ? SYNC_POL : ~SYNC_POL;
            vsync_d       = vs_act ? SYNC_POL : ~SYNC_POL;
            pix_x_d       = vis ? COORD_W'(h_cnt_q) : '0;
            pix_y_d       = vis ? COORD_W'(v_cnt_q) : '0;
            frame_start_d = first_q && (h_cnt_q == '0) && (v_cnt_q == '0);
        end
    end

    // Counter and output registers; reset returns everything to idle at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            first_q       <= 1'b1;
            video_on_q    <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            first_q       <= first_d;
            video_on_q    <= video_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.pix_tick    = tick;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.video_on    = video_on_q;
    assign vga.pix_x       = pix_x_q;
    assign vga.pix_y       = pix_y_q;
    assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Bench for vga_sync_ctrl: three builds (full 640x480 /4, short-frame /1 active-high, tiny /3).
// Latency: outputs checked every clk against an elapsed-pixel-count model.
// Backpressure: en toggled and rst pulsed mid-scan.
module tb_vga_sync_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;

    initial forever #5 clk = ~clk;

    vga_sync_ctrl_if if_a ();
    vga_sync_ctrl_if if_b ();
    vga_sync_ctrl_if if_c ();
    assign if_a.en = en;
    assign if_b.en = en;
    assign if_c.en = en;

    vga_sync_ctrl #(.CLK_DIV(4), .SYNC_POL(1'b0)) dut_a (
        .clk (clk), .rst (rst), .vga (if_a)
    );
    vga_sync_ctrl #(.CLK_DIV(1), .SYNC_POL(1'b1),
                    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(2)) dut_b (
        .clk (clk), .rst (rst), .vga (if_b)
    );
    vga_sync_ctrl #(.CLK_DIV(3), .SYNC_POL(1'b0),
                    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(2)) dut_c (
        .clk (clk), .rst (rst), .vga (if_c)
    );

    localparam int P_D  [3] = '{4, 1, 3};
    localparam int P_HV [3] = '{640, 640, 8};
    localparam int P_HF [3] = '{16, 16, 2};
    localparam int P_HS [3] = '{96, 96, 3};
    localparam int P_HB [3] = '{48, 48, 3};
    localparam int P_VV [3] = '{480, 4, 4};
    localparam int P_VF [3] = '{10, 1, 1};
    localparam int P_VS [3] = '{2, 2, 2};
    localparam int P_VB [3] = '{33, 2, 2};
    localparam bit P_POL[3] = '{1'b0, 1'b1, 1'b0};

    // Gathered DUT outputs
    logic       o_tick[3], o_hs[3], o_vs[3], o_vo[3], o_fs[3];
    logic [9:0] o_x[3], o_y[3];
    assign o_tick[0] = if_a.pix_tick; assign o_tick[1] = if_b.pix_tick; assign o_tick[2] = if_c.pix_tick;
    assign o_hs[0]   = if_a.hsync;    assign o_hs[1]   = if_b.hsync;    assign o_hs[2]   = if_c.hsync;
    assign o_vs[0]   = if_a.vsync;    assign o_vs[1]   = if_b.vsync;    assign o_vs[2]   = if_c.vsync;
    assign o_vo[0]   = if_a.video_on; assign o_vo[1]   = if_b.video_on; assign o_vo[2]   = if_c.video_on;
    assign o_fs[0]   = if_a.frame_start; assign o_fs[1] = if_b.frame_start; assign o_fs[2] = if_c.frame_start;
    assign o_x[0]    = if_a.pix_x;    assign o_x[1]    = if_b.pix_x;    assign o_x[2]    = if_c.pix_x;
    assign o_y[0]    = if_a.pix_y;    assign o_y[1]    = if_b.pix_y;    assign o_y[2]    = if_c.pix_y;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, want, want, $time);
        end
    endtask

    // Model state: n = clks with en high since the scan was last cleared
    longint     n[3];
    bit         e_vo[3], e_hs[3], e_vs[3], e_fs[3];
    logic [9:0] e_x[3], e_y[3];
    longint     m_ht, m_vt, m_p, m_h, m_v;

    initial begin
        for (int i = 0; i < 3; i++) begin
            n[i] = 0; e_vo[i] = 1'b0; e_fs[i] = 1'b0;
            e_hs[i] = !P_POL[i]; e_vs[i] = !P_POL[i]; e_x[i] = '0; e_y[i] = '0;
        end
        forever begin
            @(posedge clk or posedge rst);
            for (int i = 0; i < 3; i++) begin
                if (rst || !en) begin
                    n[i] = 0; e_vo[i] = 1'b0; e_fs[i] = 1'b0;
                    e_hs[i] = !P_POL[i]; e_vs[i] = !P_POL[i]; e_x[i] = '0; e_y[i] = '0;
                end else begin
                    m_ht = P_HV[i] + P_HF[i] + P_HS[i] + P_HB[i];
                    m_vt = P_VV[i] + P_VF[i] + P_VS[i] + P_VB[i];
                    m_p  = n[i] / P_D[i];
                    m_h  = m_p % m_ht;
                    m_v  = (m_p / m_ht) % m_vt;
                    e_vo[i] = (m_h < P_HV[i]) && (m_v < P_VV[i]);
                    e_hs[i] = (m_h >= P_HV[i] + P_HF[i] && m_h < P_HV[i] + P_HF[i] + P_HS[i])
                              ? P_POL[i] : !P_POL[i];
                    e_vs[i] = (m_v >= P_VV[i] + P_VF[i] && m_v < P_VV[i] + P_VF[i] + P_VS[i])
                              ? P_POL[i] : !P_POL[i];
                    e_x[i]  = e_vo[i] ? m_h[9:0] : 10'd0;
                    e_y[i]  = e_vo[i] ? m_v[9:0] : 10'd0;
                    e_fs[i] = (n[i] % (P_D[i] * m_ht * m_vt)) == 0;
                    n[i]++;
                end
            end
        end
    end

    // Per-signal run trackers: k = 0 hsync active, 1 vsync active, 2 frame_start, 3 video_on, 4 pix_tick
    int cyc = 0;
    int t_start[3][5], t_len[3][5], t_per[3][5], hi_cnt[3][5];
    bit t_prev[3][5];
    int mx[3], my[3];

    initial begin
        bit          act[5];
        bit          et;
        logic [24:0] aw, ew;
        for (int i = 0; i < 3; i++) begin
            mx[i] = 0; my[i] = 0;
            for (int k = 0; k < 5; k++) begin
                t_start[i][k] = -1; t_len[i][k] = 0; t_per[i][k] = 0;
                hi_cnt[i][k] = 0; t_prev[i][k] = 1'b0;
            end
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 3; i++) begin
                et = !rst && en && ((n[i] % P_D[i]) == P_D[i] - 1);
                aw = {o_tick[i], o_hs[i], o_vs[i], o_vo[i], o_fs[i], o_x[i], o_y[i]};
                ew = {et, e_hs[i], e_vs[i], e_vo[i], e_fs[i], e_x[i], e_y[i]};
                chk($sformatf("scan%0d_cyc%0d", i, cyc), int'(aw), int'(ew));
                act[0] = (o_hs[i] == P_POL[i]);
                act[1] = (o_vs[i] == P_POL[i]);
                act[2] = o_fs[i];
                act[3] = o_vo[i];
                act[4] = o_tick[i];
                if (o_vo[i] && int'(o_x[i]) > mx[i]) mx[i] = int'(o_x[i]);
                if (o_vo[i] && int'(o_y[i]) > my[i]) my[i] = int'(o_y[i]);
                for (int k = 0; k < 5; k++) begin
                    if (act[k]) hi_cnt[i][k]++;
                    if (act[k] && !t_prev[i][k]) begin
                        if (t_start[i][k] >= 0) t_per[i][k] = cyc - t_start[i][k];
                        t_start[i][k] = cyc;
                    end
                    if (!act[k] && t_prev[i][k]) t_len[i][k] = cyc - t_start[i][k];
                    t_prev[i][k] = act[k];
                end
            end
        end
    end

    // Directed sequence with hand-computed expectations
    initial begin
        int fs_seen;
        int found;
        int rel_cyc;

        @(negedge clk);
        chk("rst_hsync_a",    int'(if_a.hsync), 1);
        chk("rst_vsync_a",    int'(if_a.vsync), 1);
        chk("rst_video_on_a", int'(if_a.video_on), 0);
        chk("rst_pix_x_a",    int'(if_a.pix_x), 0);
        chk("rst_fs_a",       int'(if_a.frame_start), 0);
        chk("rst_tick_b",     int'(if_b.pix_tick), 0);
        chk("rst_hsync_b",    int'(if_b.hsync), 0);

        repeat (9) @(posedge clk);
        #6 rst = 1'b0;
        rel_cyc = cyc;
        fs_seen = 0;
        repeat (2) begin @(negedge clk); fs_seen += int'(if_a.frame_start); end
        chk("fs_after_release_a", fs_seen, 1);

        repeat (6500) @(posedge clk);
        #1;
        chk("tick_period_a",    t_per[0][4], 4);
        chk("hsync_width_a",    t_len[0][0], 384);
        chk("hsync_period_a",   t_per[0][0], 3200);
        chk("video_on_width_a", t_len[0][3], 2560);
        chk("pix_x_max_a",      mx[0], 639);
        chk("tick_const_b",     hi_cnt[1][4], cyc - rel_cyc);
        chk("hsync_width_b",    t_len[1][0], 96);
        chk("hsync_period_b",   t_per[1][0], 800);
        chk("vsync_width_b",    t_len[1][1], 1600);
        chk("pix_y_max_b",      my[1], 3);
        chk("fs_period_c",      t_per[2][2], 432);
        chk("vsync_width_c",    t_len[2][1], 96);
        chk("pix_y_max_c",      my[2], 3);

        found = 0;
        for (int k = 0; k < 4000 && found == 0; k++) begin
            @(negedge clk);
            if (if_a.video_on && if_a.pix_x == 10'd300) found = 1;
        end
        chk("wait_x300_a", found, 1);
        @(posedge clk); #1 en = 1'b0;
        @(posedge clk); #1;
        chk("en_drop_video_on_a", int'(if_a.video_on), 0);
        chk("en_drop_hsync_a",    int'(if_a.hsync), 1);
        chk("en_drop_pix_x_a",    int'(if_a.pix_x), 0);
        chk("en_drop_vsync_b",    int'(if_b.vsync), 0);
        repeat (9) @(posedge clk);
        #1 en = 1'b1;
        fs_seen = 0;
        repeat (2) begin @(negedge clk); fs_seen += int'(if_a.frame_start); end
        chk("fs_after_en_a",     fs_seen, 1);
        chk("restart_video_on_a", int'(if_a.video_on), 1);
        chk("restart_pix_xy_a",  int'({if_a.pix_x, if_a.pix_y}), 0);

        found = 0;
        for (int k = 0; k < 4000 && found == 0; k++) begin
            @(negedge clk);
            if (!if_a.hsync) found = 1;
        end
        chk("wait_hsync_a", found, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_hsync_a",    int'(if_a.hsync), 1);
        chk("rst_async_video_on_a", int'(if_a.video_on), 0);
        chk("rst_async_pix_xy_a",   int'({if_a.pix_x, if_a.pix_y}), 0);
        fs_seen = 0;
        repeat (5) begin
            @(negedge clk);
            fs_seen += int'(if_a.frame_start) + int'(if_b.frame_start) + int'(if_c.frame_start);
        end
        chk("fs_during_rst", fs_seen, 0);
        @(posedge clk); #1 rst = 1'b0;
        fs_seen = 0;
        repeat (2) begin @(negedge clk); fs_seen += int'(if_a.frame_start); end
        chk("fs_after_rst_a", fs_seen, 1);
        repeat (20) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_sync_ctrl.md
Name: vga_sync_ctrl

Overview:
Sequences the VGA scan for the rectangle display. It derives a pixel-rate clock enable from the system clock with an internal divider. It runs horizontal and vertical scan counters and drives registered hsync, vsync, video_on and pixel coordinates to the rectangle drawing logic and the VGA pins. Default timing is 640x480@60 Hz from a 100 MHz clk with CLK_DIV=4.

Parameters:
CLK_DIV, 4, system clocks per pixel; legal range 1..16
H_VIS, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels); H_TOTAL = sum of the four = 800
V_VIS, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines); V_TOTAL = 525
SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  scan enable; low = hold scan idle
pix_tick  out  1  one-clk pixel-rate enable for downstream logic
hsync  out  1  horizontal sync, polarity per SYNC_POL
vsync  out  1  vertical sync, polarity per SYNC_POL
video_on  out  1  high while the output pixel is in the visible area
pix_x  out  10  visible column 0..H_VIS-1; 0 when video_on=0
pix_y  out  10  visible row 0..V_VIS-1; 0 when video_on=0
frame_start  out  1  one-clk pulse at the first output cycle of pixel (0,0)

Behaviour:
- Reset (async assert, sync release): div, h_cnt and v_cnt = 0. pix_tick=0, video_on=0, pix_x=pix_y=0, frame_start=0, hsync=vsync=~SYNC_POL (inactive).
- Divider: div counts 0..CLK_DIV-1 while en=1 and wraps. pix_tick=1 exactly when div==CLK_DIV-1 and en=1. With CLK_DIV=1, pix_tick is constantly high while en=1.
- Horizontal counter: on pix_tick, h_cnt increments; at H_TOTAL-1 it wraps to 0.
- Vertical counter: on pix_tick with h_cnt==H_TOTAL-1, v_cnt increments; at V_TOTAL-1 it wraps to 0.
- Output decode, from current h_cnt/v_cnt, registered, exactly 1 clk latency:
  - video_on = (h_cnt<H_VIS) && (v_cnt<V_VIS)
  - hsync active when H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC (656..751)
  - vsync active when V_VIS+V_FP <= v_cnt < V_VIS+V_FP+V_SYNC (490..491)
  - pix_x/pix_y = h_cnt/v_cnt when visible, else 0
- frame_start: single clk pulse in the first cycle where the registered outputs reflect h_cnt=0, v_cnt=0. It fires after every wrap and after reset/en re-enable.
- en low: synchronous clear of div, h_cnt and v_cnt. Next clk, outputs take their reset values. While en stays low, frame_start is not produced.
- en rising: scan restarts at (0,0). frame_start pulses 1 clk after the first cycle with en=1, once counters are at 0.
- Reset mid-frame: immediate return to reset values. No partial sync pulse is held.
- Counter widths: h_cnt and v_cnt are clog2(TOTAL) bits, 10 bits at defaults. No arithmetic overflow is possible because wrap occurs at TOTAL-1.

Decomposition:
- Package vga_timing_pkg: H/V timing constants for 640x480@60, derived H_TOTAL/V_TOTAL, sync start/end constants, and a coordinate width constant (10).
- Sub-module pix_tick_gen (param CLK_DIV; ports clk, rst, en, tick): a clock-enable divider that replaces clock-output division. Everything downstream stays on clk.

Test Plan:
1. Reset held 100 ns, then released with en=1 -> all outputs at reset values during reset. pix_tick period is exactly 4 clk. frame_start pulses once, within 2 clk of release.
2. Free run for one line -> hsync low for 384 clk, period 3200 clk. video_on high for 2560 clk per visible line. pix_x steps 0..639, each value held 4 clk.
3. Free run for one frame -> vsync low for 6400 clk. frame_start period is 1,680,000 clk. pix_y reaches 479 on the last visible line. video_on=0 for lines 480..524.
4. en dropped at h_cnt=300, v_cnt=100 for 10 clk, then raised -> 1 clk after the drop, video_on=0 and syncs are inactive. After the rise, the scan restarts at (0,0) and frame_start pulses.
5. rst asserted during the hsync pulse -> hsync goes inactive immediately (asynchronously). Counters read 0 and no frame_start occurs while rst=1.
6. CLK_DIV=1, SYNC_POL=1 build -> pix_tick is constantly 1. hsync is high for 96 clk with a period of 800 clk. vsync is high for 1600 clk.
